// File: rtl/fetch_unit_if.sv
// Instruction-memory request channel plus the fetched-instruction handshake
// between the fetch stage and its consumers (memory and execute side).
interface fetch_unit_if;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic [31:0] instruction;
  logic        instr_valid;
  logic        instr_accept;

  // Fetch stage side
  modport master (
    output imem_addr,
    output imem_req,
    input  imem_rdata,
    input  imem_ready,
    output instruction,
    output instr_valid,
    input  instr_accept
  );

  // Memory / execute side
  modport slave (
    input  imem_addr,
    input  imem_req,
    output imem_rdata,
    output imem_ready,
    input  instruction,
    input  instr_valid,
    output instr_accept
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the PC, fetches one word at a time through a
// ready handshake, holds it until the execute side accepts it, then advances
// the PC (sequential, jump, or taken branch).
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         reset,
  fetch_unit_if.master bus,
  input  logic         is_jump,
  input  logic         is_branch,
  input  logic         branch_taken,
  input  logic [25:0]  addr26,
  input  logic [15:0]  imm16,
  output logic [31:0]  pc,
  output logic [31:0]  retired
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t      state_reg;
  state_t      state_next;
  logic [31:0] pc_reg;
  logic [31:0] pc_next;
  logic [31:0] instr_reg;
  logic [31:0] retired_reg;
  logic [31:0] pc4;
  logic [31:0] branch_off;
  logic        fetch_done;
  logic        accept_fire;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    state_next = FETCH;
      FETCH:   if (bus.imem_ready)   state_next = HOLD;
      HOLD:    if (bus.instr_accept) state_next = FETCH;
      default: state_next = IDLE;
    endcase
  end

  // State-decoded outputs and handshake completion strobes
  always_comb begin
    bus.imem_req    = 1'b0;
    bus.instr_valid = 1'b0;
    fetch_done      = 1'b0;
    accept_fire     = 1'b0;
    case (state_reg)
      FETCH: begin
        bus.imem_req = 1'b1;
        fetch_done   = bus.imem_ready;
      end
      HOLD: begin
        bus.instr_valid = 1'b1;
        accept_fire     = bus.instr_accept;
      end
      default: ;
    endcase
  end

  // Next PC: jump wins over branch; not-taken branch falls through to pc+4
  always_comb begin
    pc4        = pc_reg + 32'd4;
    branch_off = {{14{imm16[15]}}, imm16, 2'b00};
    pc_next    = pc4;
    if (is_jump) begin
      pc_next = {pc4[31:28], addr26, 2'b00};
    end else if (is_branch && branch_taken) begin
      pc_next = pc4 + branch_off;
    end
  end

  // Datapath registers: PC, latched instruction word, retire counter
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_reg      <= RESET_PC;
      instr_reg   <= 32'd0;
      retired_reg <= 32'd0;
    end else begin
      if (fetch_done) begin
        instr_reg <= bus.imem_rdata;
      end
      if (accept_fire) begin
        pc_reg      <= pc_next;
        retired_reg <= retired_reg + 32'd1;
      end
    end
  end

  assign bus.imem_addr   = pc_reg;
  assign bus.instruction = instr_reg;
  assign pc              = pc_reg;
  assign retired         = retired_reg;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a transaction-level reference model that
// is compared against every output on every falling edge.
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic        is_jump;
  logic        is_branch;
  logic        branch_taken;
  logic [25:0] addr26;
  logic [15:0] imm16;
  logic [31:0] pc;
  logic [31:0] retired;

  int compared   = 0;
  int mismatched = 0;

  fetch_unit_if bus_if ();

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus_if.master),
    .is_jump      (is_jump),
    .is_branch    (is_branch),
    .branch_taken (branch_taken),
    .addr26       (addr26),
    .imm16        (imm16),
    .pc           (pc),
    .retired      (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Phase: 0 = just reset, 1 = waiting for memory, 2 = word waiting for accept
  int          m_phase = 0;
  logic [31:0] m_pc    = 32'd0;
  logic [31:0] m_instr = 32'd0;
  logic [31:0] m_ret   = 32'd0;
  bit          m_init  = 0;

  function automatic logic [31:0] model_next_pc(logic [31:0] cur, bit j, bit b, bit t,
                                                logic [25:0] a26, logic [15:0] imm);
    logic [31:0] p4;
    logic [31:0] off;
    p4  = cur + 32'd4;
    off = {{16{imm[15]}}, imm} * 32'd4;
    if (j)           return (p4 & 32'hF000_0000) | ({6'd0, a26} * 32'd4);
    else if (b && t) return p4 + off;
    else             return p4;
  endfunction

  always @(posedge clk) begin
    m_init = 1;
    if (reset) begin
      m_phase = 0;
      m_pc    = 32'd0;
      m_instr = 32'd0;
      m_ret   = 32'd0;
    end else if (m_phase == 0) begin
      m_phase = 1;
    end else if (m_phase == 1) begin
      if (bus_if.imem_ready) begin
        m_instr = bus_if.imem_rdata;
        m_phase = 2;
      end
    end else if (bus_if.instr_accept) begin
      m_pc    = model_next_pc(m_pc, is_jump, is_branch, branch_taken, addr26, imm16);
      m_ret   = m_ret + 32'd1;
      m_phase = 1;
    end
  end

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model
  always @(negedge clk) begin
    if (m_init) begin
      check32("imem_req",    {31'd0, bus_if.imem_req},    {31'd0, m_phase == 1});
      check32("instr_valid", {31'd0, bus_if.instr_valid}, {31'd0, m_phase == 2});
      check32("imem_addr",   bus_if.imem_addr,   m_pc);
      check32("pc",          pc,                 m_pc);
      check32("instruction", bus_if.instruction, m_instr);
      check32("retired",     retired,            m_ret);
    end
  end

  // ---------------- stimulus ----------------
  task automatic scramble_decoder();
    is_jump      = 1'($urandom);
    is_branch    = 1'($urandom);
    branch_taken = 1'($urandom);
    addr26       = 26'($urandom);
    imm16        = 16'($urandom);
  endtask

  task automatic do_fetch(input logic [31:0] data, input int waits);
    bit seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus_if.imem_req) begin
        seen = 1;
        break;
      end
      @(negedge clk);
    end
    if (!seen) begin
      compared++;
      mismatched++;
      $display("FAIL fetch_timeout: imem_req never rose");
    end
    for (int w = 0; w < waits; w++) begin
      bus_if.imem_ready = 1'b0;
      bus_if.imem_rdata = $urandom;
      @(negedge clk);
    end
    bus_if.imem_ready = 1'b1;
    bus_if.imem_rdata = data;
    @(negedge clk);
    bus_if.imem_ready = 1'b0;
    bus_if.imem_rdata = $urandom;
  endtask

  task automatic do_accept(input bit j, input bit b, input bit t,
                           input logic [25:0] a26, input logic [15:0] imm);
    bit seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus_if.instr_valid) begin
        seen = 1;
        break;
      end
      @(negedge clk);
    end
    if (!seen) begin
      compared++;
      mismatched++;
      $display("FAIL accept_timeout: instr_valid never rose");
    end
    is_jump             = j;
    is_branch           = b;
    branch_taken        = t;
    addr26              = a26;
    imm16               = imm;
    bus_if.instr_accept = 1'b1;
    @(negedge clk);
    bus_if.instr_accept = 1'b0;
    scramble_decoder();
    $display("accept j=%0d b=%0d t=%0d -> pc=%h retired=%0d", j, b, t, pc, retired);
  endtask

  initial begin
    reset               = 1'b1;
    bus_if.imem_ready   = 1'b0;
    bus_if.imem_rdata   = 32'd0;
    bus_if.instr_accept = 1'b0;
    scramble_decoder();

    // Reset held two cycles
    @(negedge clk);
    check32("rst_req",   {31'd0, bus_if.imem_req}, 32'd0);
    @(negedge clk);
    check32("rst_valid", {31'd0, bus_if.instr_valid}, 32'd0);
    check32("rst_pc",    pc, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check32("first_req",  {31'd0, bus_if.imem_req}, 32'd1);
    check32("first_addr", bus_if.imem_addr, 32'd0);

    // Sequential
    do_fetch(32'h2010_FEFE, 0);
    check32("seq_instr", bus_if.instruction, 32'h2010_FEFE);
    check32("seq_valid", {31'd0, bus_if.instr_valid}, 32'd1);
    do_accept(0, 0, 0, 26'h0, 16'h0);
    check32("seq_addr",    bus_if.imem_addr, 32'd4);
    check32("seq_retired", retired, 32'd1);

    // Jumps, including jump priority over a taken branch
    do_fetch(32'h0810_0004, 0);
    do_accept(1, 0, 0, 26'h010_0004, 16'h0);
    check32("jump_far", pc, 32'h0040_0010);
    do_fetch(32'h0800_0004, 0);
    do_accept(1, 0, 0, 26'h4, 16'h0);
    check32("jump", pc, 32'h0000_0010);
    do_fetch(32'h0810_0004, 0);
    do_accept(1, 0, 0, 26'h010_0004, 16'h0);
    do_fetch(32'h0800_0004, 0);
    do_accept(1, 1, 1, 26'h4, 16'h1234);
    check32("jump_prio", pc, 32'h0000_0010);

    // Branches from pc 0x20
    do_fetch(32'h0800_0008, 0);
    do_accept(1, 0, 0, 26'h8, 16'h0);
    check32("to_20", pc, 32'h20);
    do_fetch(32'h1000_FFFD, 0);
    do_accept(0, 1, 1, 26'h0, 16'hFFFD);
    check32("br_taken", pc, 32'h18);
    do_fetch(32'h0800_0008, 0);
    do_accept(1, 0, 0, 26'h8, 16'h0);
    do_fetch(32'h1000_FFFD, 0);
    do_accept(0, 1, 0, 26'h0, 16'hFFFD);
    check32("br_not_taken", pc, 32'h24);

    // Wait states with toggling read data
    do_fetch(32'hAAAA_5555, 3);
    check32("wait_instr", bus_if.instruction, 32'hAAAA_5555);
    do_accept(0, 0, 0, 26'h0, 16'h0);
    check32("wait_pc", pc, 32'h28);

    // Wrap of pc+4 at the top of the address space
    do_fetch(32'h0800_0000, 0);
    do_accept(1, 0, 0, 26'h0, 16'h0);
    do_fetch(32'h1000_FFFE, 0);
    do_accept(0, 1, 1, 26'h0, 16'hFFFE);
    check32("to_top", pc, 32'hFFFF_FFFC);
    do_fetch(32'h0000_0000, 0);
    do_accept(0, 0, 0, 26'h0, 16'h0);
    check32("wrap_pc", pc, 32'h0);
    check32("wrap_retired", retired, 32'd13);

    // Reset in HOLD together with a pending accept
    do_fetch(32'h1234_5678, 0);
    reset               = 1'b1;
    bus_if.instr_accept = 1'b1;
    @(negedge clk);
    bus_if.instr_accept = 1'b0;
    check32("hold_rst_valid",   {31'd0, bus_if.instr_valid}, 32'd0);
    check32("hold_rst_pc",      pc, 32'd0);
    check32("hold_rst_retired", retired, 32'd0);

    // Reset mid-fetch, then late ready while IDLE is ignored
    reset = 1'b0;
    @(negedge clk);
    check32("refetch_req", {31'd0, bus_if.imem_req}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check32("midfetch_req", {31'd0, bus_if.imem_req}, 32'd0);
    reset             = 1'b0;
    bus_if.imem_ready = 1'b1;
    bus_if.imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    bus_if.imem_ready = 1'b0;
    check32("idle_ready_instr", bus_if.instruction, 32'd0);
    check32("idle_ready_valid", {31'd0, bus_if.instr_valid}, 32'd0);

    // Normal operation resumes
    do_fetch(32'h0000_0020, 1);
    do_accept(0, 0, 0, 26'h0, 16'h0);
    check32("post_pc",      pc, 32'd4);
    check32("post_retired", retired, 32'd1);

    @(negedge clk);
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage for the single-cycle MIPS processor. The block holds the program counter and requests instruction words from instruction memory through a ready handshake. It presents each fetched word to the `control` decoder and computes the next PC from the decoder's `is_jump`, `is_branch`, `addr26` and `imm16` outputs plus the branch-condition result. It sits directly upstream of `control`, and `instruction` feeds its `instruction` input.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset. Must be word-aligned.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  one clock; reset is synchronous and active-high.
- `imem_addr`  out  32  fetch address; always equals `pc`.
- `imem_req`  out  1  fetch request; high only in state FETCH.
- `imem_rdata`  in  32  instruction word from memory; valid when `imem_ready` is high.
- `imem_ready`  in  1  memory completes the current request this cycle.
- `instruction`  out  32  registered fetched word, driven to `control`.
- `instr_valid`  out  1  `instruction` is valid and waiting to be executed.
- `instr_accept`  in  1  the execute side finished the current instruction; the PC advances.
- `is_jump`  in  1  from `control`.
- `is_branch`  in  1  from `control`.
- `branch_taken`  in  1  branch condition result from the ALU/comparator.
- `addr26`  in  26  jump target field from `control`.
- `imm16`  in  16  branch offset field from `control`.
- `pc`  out  32  address of the current instruction.
- `retired`  out  32  count of accepted instructions; wraps modulo 2^32.

## Operation
- FSM states:
  - IDLE: entered on reset; unconditionally moves to FETCH on the next edge.
  - FETCH: `imem_req`=1. On `imem_ready`=1, `instruction`<=`imem_rdata`, `instr_valid`<=1, then go to HOLD. On `imem_ready`=0, stay in FETCH.
  - HOLD: `instr_valid`=1. On `instr_accept`=1, `pc`<=next_pc, `retired`<=`retired`+1, `instr_valid`<=0, then go to FETCH. On `instr_accept`=0, stay in HOLD.
- next_pc uses pc4 = `pc`+4, computed modulo 2^32:
  - If `is_jump`=1: next_pc = {pc4[31:28], `addr26`, 2'b00}.
  - Else if `is_branch`=1 and `branch_taken`=1: next_pc = pc4 + ({{14{imm16[15]}}, imm16, 2'b00}), computed modulo 2^32.
  - Otherwise: next_pc = pc4.
- `is_jump` has priority when both `is_jump` and `is_branch` are high.
- `is_branch`=1 with `branch_taken`=0 selects pc4.
- Decoder and branch inputs are sampled only on the accept edge in HOLD. They are ignored at all other times.
- `instr_accept` is ignored in IDLE and FETCH.
- `imem_rdata` is ignored unless the block is in FETCH and `imem_ready`=1.
- `instruction` holds its value after accept until the next completed fetch overwrites it.

## Timing
- Reset values, forced on any edge with `reset`=1 regardless of state:
  - state = IDLE
  - `pc` = `RESET_PC`
  - `instruction` = 0
  - `instr_valid` = 0
  - `retired` = 0
  - `imem_req` = 0
- First request: `imem_req` rises in the first cycle after the first edge with `reset`=0, i.e. one cycle after release.
- Minimum throughput is 2 cycles per instruction with zero-wait memory: FETCH with ready, then HOLD with accept.
- Each memory wait cycle adds one cycle. `imem_addr` stays stable throughout FETCH.
- `pc` changes exactly on the accept edge. The new `imem_req` with the new `imem_addr` is visible in the following cycle.
- Reset mid-fetch: the outstanding request is abandoned. `imem_req` is low after the reset edge, and a late `imem_ready` is ignored because the state is IDLE.
- Reset in HOLD: `instr_valid` drops and `retired` is not incremented.
- Wrap-around:
  - pc4 from 32'hFFFF_FFFC is 0.
  - `retired` wraps from 32'hFFFF_FFFF to 0.

## Test plan
- **Reset:** `RESET_PC`=0; hold `reset` high for 2 cycles, then release -> during reset `instr_valid`=0, `imem_req`=0, `pc`=0; one cycle after release `imem_req`=1, `imem_addr`=0.
- **Sequential:** `imem_ready`=1 with `imem_rdata`=32'h2010FEFE, then `instr_accept` with no jump or branch -> `instruction`=32'h2010FEFE, `instr_valid` pulses high, next `imem_addr`=4, `retired`=1.
- **Jump:** `pc`=32'h0040_0010, `is_jump`=1, `addr26`=26'h4, accept -> `pc`=32'h0000_0010. Repeat with `is_branch`=1 and `branch_taken`=1 as well -> same result (jump priority).
- **Branch:** `pc`=32'h20, `imm16`=16'hFFFD, `is_branch`=1:
  - `branch_taken`=1 -> `pc`=32'h18.
  - `branch_taken`=0 -> `pc`=32'h24.
- **Wait states:** hold `imem_ready` low for 3 cycles while `imem_rdata` toggles -> `imem_req`=1 and `imem_addr` constant, `instr_valid`=0; the fourth cycle with ready high latches only that cycle's data.
- **Boundaries:**
  - `pc`=32'hFFFF_FFFC, sequential accept -> `pc`=0.
  - Assert `reset` in HOLD -> `instr_valid`=0, `pc`=`RESET_PC`, `retired` unchanged by the pending accept.
  - Assert `imem_ready` in IDLE -> ignored.
